// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce
//   Drives the columns of a 4x4 keypad, synchronises and debounces the row
//   returns, and resolves one key press into a 4-bit hex code presented on a
//   single-entry valid/ready buffer.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   row_in     raw keypad rows (active-high, asynchronous to clk)
//   col_out    one-hot column drive (always 1 << col_sel)
//   col_sel    binary index of the driven column
//   key_code   resolved key: col_sel*4 + row index
//   key_valid  key_code holds an unconsumed key
//   key_ready  consumer accepts key_code when high together with key_valid
//   key_held   a debounced key is currently down
//   overrun    sticky: a committed key was dropped because the buffer was full
module keypad_scan_debounce #(
  parameter logic [15:0] SCAN_DIV     = 16'd1000,
  parameter logic [7:0]  DEBOUNCE_CNT = 8'd20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [1:0] col_sel,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overrun
);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_sync1;
  logic [3:0]  r_sync2;
  logic [15:0] r_div;
  logic [1:0]  r_col;
  logic [1:0]  r_row;
  logic [7:0]  r_cnt;
  logic [3:0]  r_code;
  logic        r_valid;
  logic        r_held;
  logic        r_ovr;

  logic        w_sample;
  logic        w_row_hit;
  logic [7:0]  w_cnt_inc;
  logic        w_cnt_done;
  logic        w_commit;

  // Lowest set row wins when several rows are active at detection time.
  function automatic logic [1:0] f_lowest(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  assign w_sample   = (r_div == SCAN_DIV - 16'd1);
  assign w_row_hit  = r_sync2[r_row];
  assign w_cnt_inc  = r_cnt + 8'd1;
  assign w_cnt_done = (w_cnt_inc == DEBOUNCE_CNT);
  // The press is confirmed on the sample that brings the count to DEBOUNCE_CNT.
  assign w_commit   = (r_state == PRESS_DB) && w_sample && w_row_hit && w_cnt_done;

  assign col_out   = 4'b0001 << r_col;
  assign col_sel   = r_col;
  assign key_code  = r_code;
  assign key_valid = r_valid;
  assign key_held  = r_held;
  assign overrun   = r_ovr;

  // Two-flop synchroniser for the asynchronous row returns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 4'd0;
      r_sync2 <= 4'd0;
    end else begin
      r_sync1 <= row_in;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running scan divider; runs in every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= 16'd0;
    end else if (w_sample) begin
      r_div <= 16'd0;
    end else begin
      r_div <= r_div + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= SCAN;
      r_col   <= 2'd0;
      r_row   <= 2'd0;
      r_cnt   <= 8'd0;
      r_code  <= 4'd0;
      r_valid <= 1'b0;
      r_held  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      // Output buffer: a commit may coincide with a transfer, in which case
      // the new key replaces the one being taken.
      if (w_commit) begin
        if (!r_valid || key_ready) begin
          r_code  <= {r_col, r_row};
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && key_ready) begin
        r_valid <= 1'b0;
      end

      if (w_sample) begin
        case (r_state)
          SCAN: begin
            if (r_sync2 == 4'd0) begin
              r_col <= r_col + 2'd1;
            end else begin
              r_row   <= f_lowest(r_sync2);
              r_cnt   <= 8'd0;
              r_state <= PRESS_DB;
            end
          end
          PRESS_DB: begin
            if (w_row_hit) begin
              if (w_cnt_done) begin
                r_state <= HELD;
                r_held  <= 1'b1;
                r_cnt   <= 8'd0;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end else begin
              // Bounce: abandon the press and move on to the next column.
              r_state <= SCAN;
              r_col   <= r_col + 2'd1;
            end
          end
          HELD: begin
            // Release needs DEBOUNCE_CNT consecutive clean samples.
            if (!w_row_hit) begin
              if (w_cnt_done) begin
                r_state <= SCAN;
                r_held  <= 1'b0;
                r_col   <= r_col + 2'd1;
                r_cnt   <= 8'd0;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end else begin
              r_cnt <= 8'd0;
            end
          end
          default: r_state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: doc/keypad_scan_debounce.md
Name: keypad_scan_debounce

Overview:
Upstream stage of the keypad encoder and register-bank write path. It drives the 4x4 keypad columns, synchronises and debounces the row returns, and resolves one key press to a 4-bit hex code. The code is presented on a single-entry valid/ready output buffer; the consumer takes it and writes it into the register bank. The block also reports key-held status and a sticky overrun flag.

Parameters:
SCAN_DIV, 16'd1000, clock cycles each column stays driven (min 2)
DEBOUNCE_CNT, 8'd20, consecutive confirming samples needed for press and for release (min 1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
row_in  input  4  raw keypad rows, active-high, asynchronous to clk
col_out  output  4  one-hot column drive, active-high
col_sel  output  2  binary index of the driven column
key_code  output  4  resolved key, col_sel*4 + row index
key_valid  output  1  key_code holds an unconsumed key
key_ready  input  1  consumer accepts key_code when high together with key_valid
key_held  output  1  a debounced key is currently down
overrun  output  1  sticky; a committed key was dropped because the buffer was full

Behaviour:
- Reset (async, active-high) sets: state SCAN, col_sel=0, col_out=4'b0001, divider=0, debounce count=0, synchroniser=0, key_code=0, key_valid=0, key_held=0, overrun=0.
- row_in passes through a 2-flop synchroniser. All decisions use the synchronised value (rs).
- Divider counts 0..SCAN_DIV-1 and wraps. It runs in every state. The sample point is the cycle where divider==SCAN_DIV-1.
- col_out always equals 1<<col_sel.
- States:
  - SCAN:
    - At a sample point with rs==0: col_sel increments mod 4 (3 wraps to 0).
    - At a sample point with rs!=0: capture row = lowest set bit of rs, freeze col_sel, clear the debounce count, go to PRESS_DB.
  - PRESS_DB:
    - At each sample point, if rs[row]==1, increment the count. When the count reaches DEBOUNCE_CNT, commit and go to HELD.
    - At a sample point with rs[row]==0: go to SCAN and advance col_sel. No key is emitted.
  - HELD:
    - key_held=1, col_sel stays frozen.
    - At each sample point, rs[row]==0 increments the release count and rs[row]==1 clears it.
    - When the release count reaches DEBOUNCE_CNT: key_held=0, go to SCAN, advance col_sel.
- Commit (registered, effective the cycle after the deciding sample point):
  - key_valid==0, or key_valid==1 and key_ready==1 in the same cycle: key_code={col_sel,row}, key_valid=1.
  - key_valid==1 and key_ready==0: the new key is dropped, key_code is unchanged, overrun=1.
- Handshake: a transfer happens on a cycle with key_valid && key_ready. Without a simultaneous commit, key_valid=0 next cycle. key_code holds its value until the next commit. key_ready is ignored while key_valid==0.
- key_held rises in the same cycle as the commit, whether or not the key was dropped.
- overrun clears only on reset.
- Other rows going active while in PRESS_DB or HELD are ignored. Only the captured row is tracked.
- Press-to-valid latency from the first detecting sample point: DEBOUNCE_CNT*SCAN_DIV + 1 cycles. The input side adds 2 synchroniser cycles.
- Reset asserted mid-debounce or mid-HELD aborts immediately to the reset values. A key still held after reset release is detected afresh through SCAN.

Test Plan:
Use SCAN_DIV=4 and DEBOUNCE_CNT=3 unless noted.
1. Reset asserted mid-run -> all outputs at reset values immediately, asynchronously; col_out=0001 after release.
2. No keys, 20 cycles -> col_out steps 0001, 0010, 0100, 1000, 0001, each step 4 cycles; key_valid stays 0.
3. row_in=0100 held while col_sel=1, key_ready=0 -> col frozen at 1; key_valid=1 and key_code=6 exactly 13 cycles after the detecting sample point; key_held=1. Raise key_ready for one cycle -> key_valid=0 next cycle. Release row -> key_held=0 after 3 clean samples, and scanning resumes at col_sel=2.
4. Bounce: row_in=0001 during col_sel=2 for the detect sample plus 1 confirming sample, then 0 -> no key_valid, col_sel advances to 3, key_held stays 0.
5. Overrun: key_ready=0; press and release key 5, then press key 10 -> key_code stays 5, key_valid=1, overrun=1. Pulse key_ready -> key_valid=0, overrun stays 1.
6. Commit coincident with transfer: key_valid=1 with key_ready=1 on the commit cycle of key 15 -> key_code=15, key_valid stays 1, overrun=0. Also drive row_in=1010 in col 0 -> key_code=1 (lowest row wins).
